bn_demux_rr_sched: RTL and testbench

Handshaked scheduler around the N-bit 1-to-N demultiplexer datapath. It accepts a stream of DATA_WIDTH-bit words on a valid/ready input and holds each word in a one-entry register. Each word goes to exactly one of OUTPT_SIZE output lanes, chosen either by a rotating round-robin pointer or by an explicit address. It sits between a single producer and OUTPT_SIZE consumers and guarantees no word is lost or duplicated.

---
 rtl/bn_demux_rr_sched.sv | 73 +++++++
 tb/tb_bn_demux_rr_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bn_demux_rr_sched.sv
// bn_demux_rr_sched: one-entry valid/ready demux routing each word to a round-robin or addressed lane.
// Define BN_DEMUX_STATS_EN to add per-lane completed-transfer counters (lane_cnt).
module bn_demux_rr_sched #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int OUTPT_SIZE = 2**ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   mode,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic [ADDR_WIDTH-1:0]                  in_sel,
  output logic [OUTPT_SIZE-1:0]                  out_valid,
  input  logic [OUTPT_SIZE-1:0]                  out_ready,
  output logic [OUTPT_SIZE-1:0][DATA_WIDTH-1:0]  out_data,
`ifdef BN_DEMUX_STATS_EN
  output logic [OUTPT_SIZE-1:0][7:0]             lane_cnt,
`endif
  output logic [ADDR_WIDTH-1:0]                  rr_ptr
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(OUTPT_SIZE-1);
  logic [0:0]                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]                dst_q, dst_d, rr_q, rr_d, dst_in;
  logic [OUTPT_SIZE-1:0]                out_valid_q, out_valid_d, valid_new;
  logic [OUTPT_SIZE-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d, data_new;
  logic                                 in_hs, out_hs;
  always_comb begin
    out_hs    = (state_q == FULL) & out_ready[dst_q];
    in_ready  = (state_q == EMPTY) | out_ready[dst_q];
    in_hs     = in_valid & in_ready;
    dst_in    = mode ? in_sel : rr_q;
    valid_new = '0;
    valid_new[dst_in] = 1'b1;
    data_new  = '0;
    data_new[dst_in] = in_data;
    state_d     = in_hs ? FULL : out_hs ? EMPTY : state_q;
    dst_d       = in_hs ? dst_in : dst_q;
    rr_d        = (in_hs & ~mode) ? ((rr_q == LAST) ? '0 : rr_q + 1'b1) : rr_q;
    out_valid_d = in_hs ? valid_new : out_hs ? '0 : out_valid_q;
    out_data_d  = in_hs ? data_new : out_hs ? '0 : out_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      dst_q       <= '0;
      rr_q        <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rr_ptr    = rr_q;
`ifdef BN_DEMUX_STATS_EN
  logic [OUTPT_SIZE-1:0][7:0] lane_cnt_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUTPT_SIZE; i++)
      if (rst) lane_cnt_q[i] <= '0;
      else if (out_hs && dst_q == ADDR_WIDTH'(i)) lane_cnt_q[i] <= lane_cnt_q[i] + 8'd1;
  end
  assign lane_cnt = lane_cnt_q;
`endif
endmodule

// File: tb/tb_bn_demux_rr_sched.sv
// tb_bn_demux_rr_sched: directed stimulus with a lane/data scoreboard checked on every output handshake.
module tb_bn_demux_rr_sched;
  logic              clk = 1'b0;
  logic              rst, mode, in_valid, in_ready;
  logic [3:0]        in_data;
  logic [1:0]        in_sel, rr_ptr;
  logic [3:0]        out_valid, out_ready;
  logic [3:0][3:0]   out_data;
`ifdef BN_DEMUX_STATS_EN
  logic [3:0][7:0]   lane_cnt;
`endif
  int                n_cmp = 0;
  int                n_err = 0;
  logic [5:0]        sb_q[$];
  logic [1:0]        mdl_rr = 2'd0;

  always #5 clk = ~clk;

  bn_demux_rr_sched dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef BN_DEMUX_STATS_EN
    .lane_cnt(lane_cnt),
`endif
    .rr_ptr(rr_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pops on output handshake, pushes on input handshake, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      mdl_rr = 2'd0;
    end else begin
      chk("rr_model", {30'd0, rr_ptr}, {30'd0, mdl_rr});
      if (|(out_valid & out_ready)) begin
        if (sb_q.size() == 0) chk("spurious_lane", {28'd0, out_valid}, 32'd0);
        else begin
          logic [5:0]  e;
          logic [15:0] ed;
          e  = sb_q.pop_front();
          ed = '0;
          ed[e[5:4]*4 +: 4] = e[3:0];
          chk("sb_lane", {28'd0, out_valid}, 32'd1 << e[5:4]);
          chk("sb_data", {16'd0, out_data}, {16'd0, ed});
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back({mode ? in_sel : mdl_rr, in_data});
        if (!mode) mdl_rr = mdl_rr + 2'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; in_valid = 1'b1; in_data = 4'hF; in_sel = 2'd3; out_ready = 4'hF;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 4'hF;
    tick();
    // round-robin stream 1..5
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
      chk("rr_valid", {28'd0, out_valid}, 32'd1 << ((i - 1) % 4));
      chk("rr_data", {16'd0, out_data}, 32'(i) << (((i - 1) % 4) * 4));
    end
    in_valid = 1'b0;
    chk("rr_end_ptr", {30'd0, rr_ptr}, 32'd1);
    tick();
    chk("rr_drained", {28'd0, out_valid}, 32'd0);
    // backpressure on addressed lane 2
    mode = 1'b1; in_sel = 2'd2; in_data = 4'hA; in_valid = 1'b1; out_ready = 4'b1011;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {28'd0, out_valid}, 32'h4);
      chk("bp_data", {16'd0, out_data}, 32'h0A00);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 4'hF;
    tick();
    chk("bp_done", {28'd0, out_valid}, 32'd0);
    chk("bp_sb_empty", sb_q.size(), 32'd0);
    chk("bp_rr_hold", {30'd0, rr_ptr}, 32'd1);
    // simultaneous in/out handshake: FULL on lane 1, next word to lane 2
    mode = 1'b0; in_valid = 1'b1; in_data = 4'h5; out_ready = 4'h0;
    tick();
    chk("sim_full", {28'd0, out_valid}, 32'h2);
    out_ready = 4'b0010; in_data = 4'h7;
    #1;
    chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("sim_valid", {28'd0, out_valid}, 32'h4);
    chk("sim_data", {16'd0, out_data}, 32'h0700);
    chk("sim_rr", {30'd0, rr_ptr}, 32'd3);
    in_valid = 1'b0; out_ready = 4'hF;
    tick();
    // reset with word C parked on lane 3
    mode = 1'b1; in_sel = 2'd3; in_data = 4'hC; in_valid = 1'b1; out_ready = 4'h0;
    tick();
    in_valid = 1'b0;
    chk("mid_full", {28'd0, out_valid}, 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", {28'd0, out_valid}, 32'd0);
    chk("mid_data", {16'd0, out_data}, 32'd0);
    chk("mid_rr", {30'd0, rr_ptr}, 32'd0);
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_never", {28'd0, out_valid}, 32'd0);
`ifdef BN_DEMUX_STATS_EN
    mode = 1'b1; in_sel = 2'd0; in_data = 4'h3; in_valid = 1'b1;
    for (int i = 0; i < 257; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("cnt0", {24'd0, lane_cnt[0]}, 32'd1);
    chk("cnt1", {24'd0, lane_cnt[1]}, 32'd0);
    chk("cnt2", {24'd0, lane_cnt[2]}, 32'd0);
    chk("cnt3", {24'd0, lane_cnt[3]}, 32'd0);
`endif
    tick();
    chk("final_in_ready", {31'd0, in_ready}, 32'd1);
    chk("final_sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
